router_ahb_csr_master: RTL

- AHB-lite initiator that converts a simple valid/ready CSR request interface into single 32-bit AHB transfers, and returns read data and error status on a response channel.
- Used by the test/management agent, or by a neighbouring tile, to program router_cfg registers and poll router_sta registers through the router AHB CSR slave.
- One transfer outstanding at a time; no burst or address pipelining.

---
 rtl/router_csr_pkg.sv | 23 ++
 rtl/router_ahb_wait_timer.sv | 40 ++++
 rtl/router_ahb_csr_master.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/router_csr_pkg.sv
// Shared definitions for the router AHB CSR initiator: AHB-lite encodings and
// the bus-master FSM state type.
package router_csr_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } ahb_mst_state_e;

endpackage

// File: rtl/router_ahb_wait_timer.sv
// Wait-state counter for one AHB phase: cleared on phase entry, counts enabled
// cycles, flags expiry on the cycle that would reach TIMEOUT_CYCLES.
module router_ahb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);
            localparam logic [CW-1:0] TC_FULL = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] cnt_r;

            // Wait-cycle counter; saturates at TIMEOUT_CYCLES so it never wraps.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_r <= '0;
                end else if (clr) begin
                    cnt_r <= '0;
                end else if (en && (cnt_r != TC_FULL)) begin
                    cnt_r <= cnt_r + CW'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end

            assign expired = en && (cnt_r == TC_LAST);
        end
    endgenerate

endmodule

// File: rtl/router_ahb_csr_master.sv
// AHB-lite single-transfer initiator: turns a valid/ready CSR request into one
// NONSEQ word transfer and returns read data / error on a response channel.
module router_ahb_csr_master
    import router_csr_pkg::*;
#(
    parameter int unsigned AWIDTH         = 32,
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [AWIDTH-1:0] i_req_addr,
    input  logic [DWIDTH-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DWIDTH-1:0] o_rsp_rdata,
    output logic              o_rsp_error,
    output logic              o_rsp_timeout,
    output logic              o_hsel,
    output logic [AWIDTH-1:0] o_haddr,
    output logic              o_hwrite,
    output logic [1:0]        o_htrans,
    output logic [2:0]        o_hsize,
    output logic [2:0]        o_hburst,
    output logic [DWIDTH-1:0] o_hwdata,
    input  logic              i_hready,
    input  logic [DWIDTH-1:0] i_hrdata,
    input  logic [1:0]        i_hresp
);

    ahb_mst_state_e    state_r;
    ahb_mst_state_e    next_state_s;
    logic              req_ready_r;
    logic              hsel_r;
    logic [1:0]        htrans_r;
    logic [AWIDTH-1:0] haddr_r;
    logic              hwrite_r;
    logic [DWIDTH-1:0] hwdata_r;
    logic              rsp_valid_r;
    logic [DWIDTH-1:0] rsp_rdata_r;
    logic              rsp_error_r;
    logic              rsp_timeout_r;

    logic accept_s;
    logic misalign_s;
    logic bus_err_s;
    logic timer_clr_s;
    logic timer_en_s;
    logic expired_s;

    assign accept_s    = req_ready_r & i_req_valid;
    assign misalign_s  = |i_req_addr[1:0];
    assign bus_err_s   = (i_hresp == HRESP_ERROR);
    assign timer_en_s  = ((state_r == ST_ADDR) || (state_r == ST_DATA)) && !i_hready;
    assign timer_clr_s = (next_state_s != state_r);

    router_ahb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (i_hclk),
        .rst_n   (i_hreset),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (expired_s)
    );

    // Next-state decode; a completing data phase takes priority over expiry.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = misalign_s ? ST_RESP : ST_ADDR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (expired_s) begin
                    next_state_s = ST_RESP;
                end else if (i_hready) begin
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (i_hready || expired_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State and bus-side outputs, registered from the upcoming state.
    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
            hsel_r      <= 1'b0;
            htrans_r    <= HTRANS_IDLE;
            haddr_r     <= '0;
            hwrite_r    <= 1'b0;
            hwdata_r    <= '0;
        end else begin
            state_r     <= next_state_s;
            req_ready_r <= (next_state_s == ST_IDLE);
            hsel_r      <= (next_state_s == ST_ADDR);
            htrans_r    <= (next_state_s == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            if (accept_s) begin
                haddr_r  <= i_req_addr;
                hwrite_r <= i_req_write;
                hwdata_r <= i_req_wdata;
            end else begin
                haddr_r  <= haddr_r;
                hwrite_r <= hwrite_r;
                hwdata_r <= hwdata_r;
            end
        end
    end

    // Response capture: misaligned reject, data-phase completion or timeout.
    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            rsp_valid_r <= (next_state_s == ST_RESP);
            if (accept_s && misalign_s) begin
                rsp_rdata_r   <= '0;
                rsp_error_r   <= 1'b1;
                rsp_timeout_r <= 1'b0;
            end else if ((state_r == ST_DATA) && i_hready) begin
                rsp_rdata_r   <= (!hwrite_r && !bus_err_s) ? i_hrdata : '0;
                rsp_error_r   <= bus_err_s;
                rsp_timeout_r <= 1'b0;
            end else if (expired_s) begin
                rsp_rdata_r   <= '0;
                rsp_error_r   <= 1'b1;
                rsp_timeout_r <= 1'b1;
            end else if ((state_r == ST_RESP) && i_rsp_ready) begin
                rsp_rdata_r   <= '0;
                rsp_error_r   <= 1'b0;
                rsp_timeout_r <= 1'b0;
            end else begin
                rsp_rdata_r   <= rsp_rdata_r;
                rsp_error_r   <= rsp_error_r;
                rsp_timeout_r <= rsp_timeout_r;
            end
        end
    end

    assign o_req_ready   = req_ready_r;
    assign o_hsel        = hsel_r;
    assign o_htrans      = htrans_r;
    assign o_haddr       = haddr_r;
    assign o_hwrite      = hwrite_r;
    assign o_hwdata      = hwdata_r;
    assign o_hsize       = HSIZE_WORD;
    assign o_hburst      = HBURST_SINGLE;
    assign o_rsp_valid   = rsp_valid_r;
    assign o_rsp_rdata   = rsp_rdata_r;
    assign o_rsp_error   = rsp_error_r;
    assign o_rsp_timeout = rsp_timeout_r;

endmodule
